// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: walks fetch/memory/io/intack cycles through T-states,
// inserts automatic and WAIT-pin wait states, arbitrates bus hold and latches NMI.
module bus_cycle_sequencer #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int MEM_WS = 0,
  parameter int IO_WS  = 1,
  parameter int INT_WS = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [2:0]    func,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] rfsh_addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] din,
  input  logic          mwait,
  input  logic          busrq,
  input  logic          nmi,
  input  logic          nmi_clr,
  output logic [AW-1:0] ab_out,
  output logic          ab_oe,
  output logic [DW-1:0] db_out,
  output logic          db_oe,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          m1,
  output logic          mreq,
  output logic          iorq,
  output logic          rd,
  output logic          wr,
  output logic          rfsh,
  output logic          bus_oe,
  output logic          busack,
  output logic          busy,
  output logic          done,
  output logic          nmi_pend
);
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_HOLD} state_t;

  typedef struct packed {
    logic m1;
    logic mreq;
    logic iorq;
    logic rd;
    logic wr;
    logic rfsh;
    logic done;
    logic db_oe;
  } ctl_t;

  localparam logic [2:0] F_FETCH = 3'd0;
  localparam logic [2:0] F_MRD   = 3'd1;
  localparam logic [2:0] F_MWR   = 3'd2;
  localparam logic [2:0] F_IORD  = 3'd3;
  localparam logic [2:0] F_IOWR  = 3'd4;
  localparam logic [2:0] F_INTA  = 3'd5;
  localparam logic [2:0] MEM_WS3 = 3'(MEM_WS);
  localparam logic [2:0] IO_WS3  = 3'(IO_WS);
  localparam logic [2:0] INT_WS3 = 3'(INT_WS);

  state_t          state_q, state_d;
  logic [2:0]      func_q, func_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      ws_sel;
  logic [AW-1:0]   ab_q, ab_d;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic            vld_q, cap;
  logic            nmi_prev_q, nmi_pend_q, nmi_pend_d;
  ctl_t            ctl_q, ctl_d;
  logic            legal_req, mem_q, last_t;
  logic            f_fetch, f_mrd, f_mwr, f_iord, f_iowr, f_inta, f_mem, f_io, f_wr;

  assign legal_req = req && (func <= F_INTA);
  assign mem_q     = (func_q == F_MRD) || (func_q == F_MWR);
  assign last_t    = (state_q == S_T4) || (state_q == S_T3 && mem_q);
  assign ws_sel    = (func_q == F_IORD || func_q == F_IOWR) ? IO_WS3 :
                     (func_q == F_INTA) ? INT_WS3 : MEM_WS3;

  // T1 is entered only from IDLE or a last T, so this is the request latch point
  assign func_d = (state_d == S_T1) ? func : func_q;

  assign cap = (state_q == S_T2 || state_q == S_TW) && (state_d == S_T3) &&
               (func_q inside {F_FETCH, F_MRD, F_IORD, F_INTA});

  assign nmi_pend_d = (nmi && !nmi_prev_q) || (nmi_pend_q && !nmi_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      func_q     <= '0;
      cnt_q      <= '0;
      ab_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      vld_q      <= 1'b0;
      ctl_q      <= '0;
      nmi_prev_q <= nmi;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      cnt_q      <= cnt_d;
      ab_q       <= ab_d;
      if (state_d == S_T1) wdata_q <= wdata;
      if (cap) rdata_q <= din;
      vld_q      <= cap;
      ctl_q      <= ctl_d;
      nmi_prev_q <= nmi;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (busrq)          state_d = S_HOLD;
        else if (legal_req) state_d = S_T1;
      end
      S_T1: begin
        state_d = S_T2;
        cnt_d   = ws_sel;
      end
      S_T2, S_TW: begin
        if (cnt_q != 3'd0) begin
          state_d = S_TW;
          cnt_d   = cnt_q - 3'd1;
        end else if (mwait) begin
          state_d = S_TW;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3:    state_d = S_T4;
      S_HOLD:  if (!busrq) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // busrq is only honoured at cycle boundaries
    if (last_t) state_d = busrq ? S_HOLD : (legal_req ? S_T1 : S_IDLE);
  end

  assign f_fetch = (func_d == F_FETCH);
  assign f_mrd   = (func_d == F_MRD);
  assign f_mwr   = (func_d == F_MWR);
  assign f_iord  = (func_d == F_IORD);
  assign f_iowr  = (func_d == F_IOWR);
  assign f_inta  = (func_d == F_INTA);
  assign f_mem   = f_mrd | f_mwr;
  assign f_io    = f_iord | f_iowr;
  assign f_wr    = f_mwr | f_iowr;

  always_comb begin
    ctl_d = '0;
    ab_d  = ab_q;
    case (state_d)
      S_T1: begin
        ctl_d.m1    = f_fetch | f_inta;
        ctl_d.mreq  = f_fetch | f_mem;
        ctl_d.rd    = f_fetch | f_mrd;
        ctl_d.db_oe = f_wr;
        ab_d        = addr;
      end
      S_T2, S_TW: begin
        ctl_d.m1    = f_fetch | f_inta;
        ctl_d.mreq  = f_fetch | f_mem;
        ctl_d.iorq  = f_io | (f_inta && state_d == S_TW);
        ctl_d.rd    = f_fetch | f_mrd | f_iord;
        ctl_d.wr    = f_wr;
        ctl_d.db_oe = f_wr;
      end
      S_T3: begin
        ctl_d.mreq  = f_fetch | f_mem;
        ctl_d.iorq  = f_io;
        ctl_d.rd    = f_mrd | f_iord;
        ctl_d.wr    = f_iowr;
        ctl_d.rfsh  = f_fetch;
        ctl_d.done  = f_mem;
        ctl_d.db_oe = f_wr;
        if (f_fetch) ab_d = rfsh_addr;
      end
      S_T4: begin
        ctl_d.iorq  = f_io;
        ctl_d.rd    = f_iord;
        ctl_d.rfsh  = f_fetch;
        ctl_d.done  = 1'b1;
        ctl_d.db_oe = f_wr;
        if (f_fetch) ab_d = rfsh_addr;
      end
      default: ;
    endcase
  end

  assign ab_out    = ab_q;
  assign ab_oe     = (state_q != S_HOLD);
  assign bus_oe    = (state_q != S_HOLD);
  assign busack    = (state_q == S_HOLD);
  assign busy      = state_q inside {S_T1, S_T2, S_TW, S_T3, S_T4};
  assign db_out    = wdata_q;
  assign db_oe     = ctl_q.db_oe;
  assign rdata     = rdata_q;
  assign rdata_vld = vld_q;
  assign m1        = ctl_q.m1;
  assign mreq      = ctl_q.mreq;
  assign iorq      = ctl_q.iorq;
  assign rd        = ctl_q.rd;
  assign wr        = ctl_q.wr;
  assign rfsh      = ctl_q.rfsh;
  assign done      = ctl_q.done;
  assign nmi_pend  = nmi_pend_q;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer: each task runs one scenario cycle by cycle
// and compares strobe masks and data against hand-derived values.
module tb_bus_cycle_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  func = 3'd0;
  logic [15:0] addr = '0, rfsh_addr = '0;
  logic [7:0]  wdata = '0, din = '0;
  logic        mwait = 1'b0, busrq = 1'b0, nmi = 1'b0, nmi_clr = 1'b0;
  logic [15:0] ab_out;
  logic [7:0]  db_out, rdata;
  logic        ab_oe, db_oe, rdata_vld, m1, mreq, iorq, rd, wr, rfsh;
  logic        bus_oe, busack, busy, done, nmi_pend;

  integer total = 0;
  integer bad = 0;

  bus_cycle_sequencer #(.AW(16), .DW(8), .MEM_WS(0), .IO_WS(1), .INT_WS(2)) dut (
    .clk(clk), .reset(reset), .req(req), .func(func), .addr(addr),
    .rfsh_addr(rfsh_addr), .wdata(wdata), .din(din), .mwait(mwait),
    .busrq(busrq), .nmi(nmi), .nmi_clr(nmi_clr), .ab_out(ab_out), .ab_oe(ab_oe),
    .db_out(db_out), .db_oe(db_oe), .rdata(rdata), .rdata_vld(rdata_vld),
    .m1(m1), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .rfsh(rfsh),
    .bus_oe(bus_oe), .busack(busack), .busy(busy), .done(done), .nmi_pend(nmi_pend)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++;
    if ({busy, m1, mreq, iorq, rd, wr, rfsh, busack, done, rdata_vld, nmi_pend, db_oe} !== 12'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=0", {busy, m1, mreq, iorq, rd, wr, rfsh, busack, done, rdata_vld, nmi_pend, db_oe});
    end
    total++;
    if ({ab_oe, bus_oe} !== 2'b11) begin
      bad++; $display("FAIL reset_oe got=%b want=11", {ab_oe, bus_oe});
    end
    total++;
    if (ab_out !== 16'h0 || db_out !== 8'h0 || rdata !== 8'h0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h want=0", ab_out, db_out, rdata);
    end
    reset = 1'b0;
    tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_fetch;
    int m1c = 0, rdc = 0, mreqc = 0, rfshc = 0, vldc = 0, done_at = 0, vld_at = 0;
    logic [7:0]  rv = '0;
    logic [15:0] ab_seen [1:6];
    for (int c = 1; c <= 6; c++) begin
      req = (c == 1); func = 3'd0; addr = 16'h1234; rfsh_addr = 16'h0056; din = 8'hA5; mwait = 1'b0;
      tick;
      m1c += int'(m1); rdc += int'(rd); mreqc += int'(mreq); rfshc += int'(rfsh); vldc += int'(rdata_vld);
      ab_seen[c] = ab_out;
      if (done) done_at = c;
      if (rdata_vld) begin vld_at = c; rv = rdata; end
    end
    req = 1'b0;
    total++; if (m1c != 2)   begin bad++; $display("FAIL fetch_m1 got=%0d want=2", m1c); end
    total++; if (rdc != 2)   begin bad++; $display("FAIL fetch_rd got=%0d want=2", rdc); end
    total++; if (mreqc != 3) begin bad++; $display("FAIL fetch_mreq got=%0d want=3", mreqc); end
    total++; if (rfshc != 2) begin bad++; $display("FAIL fetch_rfsh got=%0d want=2", rfshc); end
    total++; if (done_at != 4) begin bad++; $display("FAIL fetch_done got=%0d want=4", done_at); end
    total++;
    if (vld_at != 3 || vldc != 1 || rv !== 8'hA5) begin
      bad++; $display("FAIL fetch_rdata at=%0d n=%0d val=%h want at=3 n=1 val=a5", vld_at, vldc, rv);
    end
    total++;
    if (ab_seen[1] !== 16'h1234 || ab_seen[2] !== 16'h1234 || ab_seen[3] !== 16'h0056 ||
        ab_seen[4] !== 16'h0056 || ab_seen[6] !== 16'h0056) begin
      bad++; $display("FAIL fetch_ab got=%h %h %h %h %h want=1234 1234 0056 0056 0056",
                      ab_seen[1], ab_seen[2], ab_seen[3], ab_seen[4], ab_seen[6]);
    end
  endtask

  task automatic test_ioread_wait;
    int iorqc = 0, rdc = 0, busyc = 0, memc = 0, first_iorq = 0, done_at = 0, vld_at = 0;
    logic [7:0] rv = '0;
    for (int c = 1; c <= 9; c++) begin
      req = (c == 1); func = 3'd3; addr = 16'h00F0; din = 8'h5A;
      mwait = (c == 4 || c == 5);
      tick;
      if (iorq && first_iorq == 0) first_iorq = c;
      iorqc += int'(iorq); rdc += int'(rd); busyc += int'(busy); memc += int'(m1) + int'(mreq);
      if (done) done_at = c;
      if (rdata_vld) begin vld_at = c; rv = rdata; end
    end
    req = 1'b0; mwait = 1'b0;
    total++; if (done_at != 7) begin bad++; $display("FAIL io_done got=%0d want=7", done_at); end
    total++;
    if (first_iorq != 2 || iorqc != 6 || rdc != 6) begin
      bad++; $display("FAIL io_strobes first=%0d iorq=%0d rd=%0d want 2/6/6", first_iorq, iorqc, rdc);
    end
    total++; if (busyc != 7 || memc != 0) begin bad++; $display("FAIL io_busy busy=%0d mem=%0d want 7/0", busyc, memc); end
    total++;
    if (vld_at != 6 || rv !== 8'h5A) begin bad++; $display("FAIL io_rdata at=%0d val=%h want 6/5a", vld_at, rv); end
  endtask

  task automatic test_back_to_back;
    logic [8:1] busy_m = '0, done_m = '0, dboe_m = '0, wr_m = '0, vld_m = '0, mreq_m = '0, rd_m = '0;
    logic [15:0] ab4 = '0;
    logic [7:0]  db1 = '0;
    for (int c = 1; c <= 8; c++) begin
      req = (c == 1 || c == 4); func = (c < 4) ? 3'd2 : 3'd1;
      addr = (c < 4) ? 16'h2000 : 16'h2100; wdata = 8'h3C; din = 8'h77;
      tick;
      busy_m[c] = busy; done_m[c] = done; dboe_m[c] = db_oe; wr_m[c] = wr;
      vld_m[c] = rdata_vld; mreq_m[c] = mreq; rd_m[c] = rd;
      if (c == 4) ab4 = ab_out;
      if (c == 1) db1 = db_out;
    end
    req = 1'b0;
    total++; if (done_m !== 8'b0010_0100) begin bad++; $display("FAIL b2b_done got=%b want=00100100", done_m); end
    total++; if (busy_m !== 8'b0011_1111) begin bad++; $display("FAIL b2b_busy got=%b want=00111111", busy_m); end
    total++; if (dboe_m !== 8'b0000_0111) begin bad++; $display("FAIL b2b_dboe got=%b want=00000111", dboe_m); end
    total++; if (wr_m !== 8'b0000_0010)   begin bad++; $display("FAIL b2b_wr got=%b want=00000010", wr_m); end
    total++;
    if (mreq_m !== 8'b0011_1111 || rd_m !== 8'b0011_1000) begin
      bad++; $display("FAIL b2b_mreq_rd got=%b/%b want=00111111/00111000", mreq_m, rd_m);
    end
    total++;
    if (vld_m !== 8'b0010_0000 || rdata !== 8'h77) begin
      bad++; $display("FAIL b2b_rdata vld=%b val=%h want=00100000/77", vld_m, rdata);
    end
    total++;
    if (ab4 !== 16'h2100 || db1 !== 8'h3C) begin bad++; $display("FAIL b2b_addr_data got=%h/%h want=2100/3c", ab4, db1); end
  endtask

  task automatic test_busrq_hold;
    logic [8:1] busy_m = '0, done_m = '0, ack_m = '0, aoe_m = '0, boe_m = '0, strb_m = '0, dboe_m = '0;
    for (int c = 1; c <= 8; c++) begin
      req = (c == 1); func = 3'd0; addr = 16'h4000;
      busrq = (c >= 3 && c <= 6);
      tick;
      busy_m[c] = busy; done_m[c] = done; ack_m[c] = busack; aoe_m[c] = ab_oe; boe_m[c] = bus_oe;
      strb_m[c] = m1 | mreq | iorq | rd | wr | rfsh; dboe_m[c] = db_oe;
    end
    req = 1'b0; busrq = 1'b0;
    total++;
    if (busy_m !== 8'b0000_1111 || done_m !== 8'b0000_1000) begin
      bad++; $display("FAIL hold_cycle busy=%b done=%b want=00001111/00001000", busy_m, done_m);
    end
    total++; if (ack_m !== 8'b0011_0000) begin bad++; $display("FAIL hold_busack got=%b want=00110000", ack_m); end
    total++;
    if (aoe_m !== 8'b1100_1111 || boe_m !== 8'b1100_1111 || dboe_m !== 8'b0) begin
      bad++; $display("FAIL hold_oe ab=%b bus=%b db=%b want=11001111/11001111/0", aoe_m, boe_m, dboe_m);
    end
    total++; if (strb_m !== 8'b0000_1111) begin bad++; $display("FAIL hold_strobes got=%b want=00001111", strb_m); end
  endtask

  task automatic test_nmi;
    busrq = 1'b1; nmi = 1'b0; nmi_clr = 1'b0;
    tick;
    total++; if (nmi_pend !== 1'b0) begin bad++; $display("FAIL nmi_init got=%b want=0", nmi_pend); end
    nmi = 1'b1; tick;
    total++; if (nmi_pend !== 1'b1) begin bad++; $display("FAIL nmi_edge got=%b want=1", nmi_pend); end
    nmi = 1'b0; tick;
    total++; if (nmi_pend !== 1'b1) begin bad++; $display("FAIL nmi_sticky got=%b want=1", nmi_pend); end
    nmi = 1'b1; nmi_clr = 1'b1; tick;
    total++; if (nmi_pend !== 1'b1) begin bad++; $display("FAIL nmi_edge_vs_clr got=%b want=1", nmi_pend); end
    nmi = 1'b0; nmi_clr = 1'b0; tick;
    total++; if (nmi_pend !== 1'b1) begin bad++; $display("FAIL nmi_hold got=%b want=1", nmi_pend); end
    nmi_clr = 1'b1; tick;
    total++; if (nmi_pend !== 1'b0) begin bad++; $display("FAIL nmi_clr got=%b want=0", nmi_pend); end
    total++; if (busack !== 1'b1) begin bad++; $display("FAIL nmi_in_hold busack=%b want=1", busack); end
    nmi_clr = 1'b0; busrq = 1'b0; tick;
    total++; if (busack !== 1'b0) begin bad++; $display("FAIL hold_release busack=%b want=0", busack); end
  endtask

  task automatic test_illegal_priority;
    req = 1'b1; func = 3'd6; tick;
    total++; if (busy !== 1'b0 || m1 !== 1'b0) begin bad++; $display("FAIL func6 busy=%b m1=%b want=0/0", busy, m1); end
    func = 3'd7; tick;
    total++; if (busy !== 1'b0 || rd !== 1'b0) begin bad++; $display("FAIL func7 busy=%b rd=%b want=0/0", busy, rd); end
    func = 3'd0; busrq = 1'b1; tick;
    total++;
    if (busack !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL busrq_wins busack=%b busy=%b want=1/0", busack, busy); end
    req = 1'b0; busrq = 1'b0; tick;
    total++; if (busack !== 1'b0) begin bad++; $display("FAIL prio_release busack=%b want=0", busack); end
  endtask

  task automatic test_reset_midcycle;
    logic [3:1] m1_m = '0, iorq_m = '0;
    for (int c = 1; c <= 3; c++) begin
      req = (c == 1); func = 3'd5; addr = 16'h0038; mwait = 1'b0; din = 8'hC3;
      tick;
      m1_m[c] = m1; iorq_m[c] = iorq;
    end
    req = 1'b0;
    total++;
    if (m1_m !== 3'b111 || iorq_m !== 3'b100) begin
      bad++; $display("FAIL inta_strobes m1=%b iorq=%b want=111/100", m1_m, iorq_m);
    end
    reset = 1'b1; nmi = 1'b1; req = 1'b1; busrq = 1'b1;
    tick;
    total++;
    if ({busy, m1, mreq, iorq, rd, wr, rfsh, busack, done, rdata_vld, nmi_pend, db_oe} !== 12'b0) begin
      bad++; $display("FAIL midrst_ctl got=%b want=0", {busy, m1, mreq, iorq, rd, wr, rfsh, busack, done, rdata_vld, nmi_pend, db_oe});
    end
    total++;
    if (ab_out !== 16'h0 || db_out !== 8'h0 || rdata !== 8'h0 || {ab_oe, bus_oe} !== 2'b11) begin
      bad++; $display("FAIL midrst_data ab=%h db=%h rdata=%h oe=%b want=0/0/0/11", ab_out, db_out, rdata, {ab_oe, bus_oe});
    end
    req = 1'b0; busrq = 1'b0; reset = 1'b0;
    tick;
    tick;
    total++;
    if (nmi_pend !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_nmi pend=%b busy=%b want=0/0", nmi_pend, busy);
    end
    nmi = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_ioread_wait;
    test_back_to_back;
    test_busrq_hold;
    test_nmi;
    test_illegal_priority;
    test_reset_midcycle;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
